// File: rtl/dcmac_pkg.sv
// Shared DCMAC segment constants: per-segment field widths and tuser bit positions.
package dcmac_pkg;

    localparam int SEG_DW     = 128;
    localparam int SEG_MTY_W  = 4;
    localparam int SEG_USER_W = 3;

    // tuser layout per segment: {ena, sop, err}
    localparam int USR_ENA = 2;
    localparam int USR_SOP = 1;
    localparam int USR_ERR = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dcmac_rx_seg_gather.sv
// Gathers IN_SEGS-wide segment groups into OUT_SEGS-wide beats. A beat closes on the
// last slot or on any eop; a sop on segment 0 mid-beat discards the stale partial.
module dcmac_rx_seg_gather
    import dcmac_pkg::*;
#(
    parameter int IN_SEGS  = 2,
    parameter int OUT_SEGS = 4,
    parameter int CNT_W    = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [IN_SEGS*SEG_DW-1:0]      in_tdata,
    input  logic [IN_SEGS*SEG_MTY_W-1:0]   in_tid,
    input  logic [IN_SEGS*SEG_USER_W-1:0]  in_tuser,
    input  logic [IN_SEGS-1:0]             in_tlast,
    input  logic                           in_tvalid,
    output logic [OUT_SEGS*SEG_DW-1:0]     out_tdata,
    output logic [OUT_SEGS*SEG_MTY_W-1:0]  out_tid,
    output logic [OUT_SEGS*SEG_USER_W-1:0] out_tuser,
    output logic [OUT_SEGS-1:0]            out_tlast,
    output logic                           out_tvalid,
    input  logic                           cnt_clear,
    output logic [CNT_W-1:0]               beat_cnt,
    output logic [CNT_W-1:0]               trunc_cnt,
    output logic [CNT_W-1:0]               drop_cnt,
    output logic                           drop_pulse
);

    localparam int RATIO  = OUT_SEGS / IN_SEGS;
    localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int IDW    = IN_SEGS * SEG_DW;
    localparam int IMW    = IN_SEGS * SEG_MTY_W;
    localparam int IUW    = IN_SEGS * SEG_USER_W;
    localparam int ODW    = OUT_SEGS * SEG_DW;
    localparam int OMW    = OUT_SEGS * SEG_MTY_W;
    localparam int OUW    = OUT_SEGS * SEG_USER_W;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    generate
        if ((IN_SEGS != 1) && (IN_SEGS != 2) && (IN_SEGS != 4)) begin : g_bad_in_segs
            $error("dcmac_rx_seg_gather: IN_SEGS must be 1, 2 or 4");
        end
        if (((OUT_SEGS % IN_SEGS) != 0) || (OUT_SEGS > 8)) begin : g_bad_out_segs
            $error("dcmac_rx_seg_gather: OUT_SEGS must be a multiple of IN_SEGS and at most 8");
        end
    endgenerate

    logic              r_valid_q, r_valid_d;
    logic [IDW-1:0]    r_data_q, r_data_d;
    logic [IMW-1:0]    r_tid_q, r_tid_d;
    logic [IUW-1:0]    r_user_q, r_user_d;
    logic [IN_SEGS-1:0] r_last_q, r_last_d;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ODW-1:0]    acc_data_q, acc_data_d;
    logic [OMW-1:0]    acc_tid_q, acc_tid_d;
    logic [OUW-1:0]    acc_user_q, acc_user_d;
    logic [OUT_SEGS-1:0] acc_last_q, acc_last_d;

    logic [ODW-1:0]    out_data_q, out_data_d;
    logic [OMW-1:0]    out_tid_q, out_tid_d;
    logic [OUW-1:0]    out_user_q, out_user_d;
    logic [OUT_SEGS-1:0] out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              trunc_pulse_q, trunc_pulse_d;
    logic              drop_pulse_q, drop_pulse_d;

    logic              realign;
    logic              complete;
    logic [SLOT_W-1:0] eff_slot;
    logic [ODW-1:0]    merged_data;
    logic [OMW-1:0]    merged_tid;
    logic [OUW-1:0]    merged_user;
    logic [OUT_SEGS-1:0] merged_last;

    // Realign detection and the beat image formed by the accumulator plus the current group.
    always_comb begin
        realign = 1'b0;
        if (RATIO > 1) begin
            realign = r_valid_q && r_user_q[USR_SOP] && (slot_q != '0);
        end
        eff_slot = realign ? '0 : slot_q;
        complete = (eff_slot == LAST_SLOT) || (|r_last_q);

        // A realigned group starts from an empty accumulator; slots above the current
        // one are already zero because the accumulator is cleared on every completion.
        merged_data = realign ? '0 : acc_data_q;
        merged_tid  = realign ? '0 : acc_tid_q;
        merged_user = realign ? '0 : acc_user_q;
        merged_last = realign ? '0 : acc_last_q;
        for (int k = 0; k < RATIO; k++) begin
            if (eff_slot == SLOT_W'(k)) begin
                merged_data[k*IDW +: IDW]     = r_data_q;
                merged_tid[k*IMW +: IMW]      = r_tid_q;
                merged_user[k*IUW +: IUW]     = r_user_q;
                merged_last[k*IN_SEGS +: IN_SEGS] = r_last_q;
            end
        end
    end

    // Next-state: input stage capture, slot/accumulator advance, beat emission.
    always_comb begin
        r_valid_d     = in_tvalid;
        r_data_d      = in_tdata;
        r_tid_d       = in_tid;
        r_user_d      = in_tuser;
        r_last_d      = in_tlast;

        slot_d        = slot_q;
        acc_data_d    = acc_data_q;
        acc_tid_d     = acc_tid_q;
        acc_user_d    = acc_user_q;
        acc_last_d    = acc_last_q;
        out_data_d    = out_data_q;
        out_tid_d     = out_tid_q;
        out_user_d    = out_user_q;
        out_last_d    = out_last_q;
        out_valid_d   = 1'b0;
        trunc_pulse_d = 1'b0;
        drop_pulse_d  = 1'b0;

        if (r_valid_q) begin
            drop_pulse_d = realign;
            if (complete) begin
                out_data_d    = merged_data;
                out_tid_d     = merged_tid;
                out_user_d    = merged_user;
                out_last_d    = merged_last;
                out_valid_d   = 1'b1;
                trunc_pulse_d = (eff_slot != LAST_SLOT);
                slot_d        = '0;
                acc_data_d    = '0;
                acc_tid_d     = '0;
                acc_user_d    = '0;
                acc_last_d    = '0;
            end else begin
                acc_data_d = merged_data;
                acc_tid_d  = merged_tid;
                acc_user_d = merged_user;
                acc_last_d = merged_last;
                slot_d     = eff_slot + SLOT_W'(1);
            end
        end
    end

    // All pipeline state; a reset drops any partial beat silently.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid_q     <= 1'b0;
            r_data_q      <= '0;
            r_tid_q       <= '0;
            r_user_q      <= '0;
            r_last_q      <= '0;
            slot_q        <= '0;
            acc_data_q    <= '0;
            acc_tid_q     <= '0;
            acc_user_q    <= '0;
            acc_last_q    <= '0;
            out_data_q    <= '0;
            out_tid_q     <= '0;
            out_user_q    <= '0;
            out_last_q    <= '0;
            out_valid_q   <= 1'b0;
            trunc_pulse_q <= 1'b0;
            drop_pulse_q  <= 1'b0;
        end else begin
            r_valid_q     <= r_valid_d;
            r_data_q      <= r_data_d;
            r_tid_q       <= r_tid_d;
            r_user_q      <= r_user_d;
            r_last_q      <= r_last_d;
            slot_q        <= slot_d;
            acc_data_q    <= acc_data_d;
            acc_tid_q     <= acc_tid_d;
            acc_user_q    <= acc_user_d;
            acc_last_q    <= acc_last_d;
            out_data_q    <= out_data_d;
            out_tid_q     <= out_tid_d;
            out_user_q    <= out_user_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            trunc_pulse_q <= trunc_pulse_d;
            drop_pulse_q  <= drop_pulse_d;
        end
    end

    assign out_tdata  = out_data_q;
    assign out_tid    = out_tid_q;
    assign out_tuser  = out_user_q;
    assign out_tlast  = out_last_q;
    assign out_tvalid = out_valid_q;
    assign drop_pulse = drop_pulse_q;

    sat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_valid_q),
        .clr    (cnt_clear),
        .cnt    (beat_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_trunc_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (trunc_pulse_q),
        .clr    (cnt_clear),
        .cnt    (trunc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (drop_pulse_q),
        .clr    (cnt_clear),
        .cnt    (drop_cnt)
    );

endmodule

// File: tb/tb_dcmac_rx_seg_gather.sv
// Directed bench: a 2->4 gather instance with wide counters and a 2->8 instance with
// 2-bit counters (for saturation). Expected beats are queued when driven.
module tb_dcmac_rx_seg_gather;

    typedef struct {
        logic [255:0] d;
        logic [7:0]   t;
        logic [5:0]   u;
        logic [1:0]   l;
    } grp_t;

    typedef struct {
        logic [1023:0] d;
        logic [31:0]   t;
        logic [23:0]   u;
        logic [7:0]    l;
        int            due;
    } beat_t;

    typedef grp_t grp4_t [4];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic cnt_clear;

    logic [255:0] a4_d, a8_d;
    logic [7:0]   a4_t, a8_t;
    logic [5:0]   a4_u, a8_u;
    logic [1:0]   a4_l, a8_l;
    logic         a4_v, a8_v;

    logic [511:0] o4_d;
    logic [15:0]  o4_t;
    logic [11:0]  o4_u;
    logic [3:0]   o4_l;
    logic         o4_v, o4_drop;
    logic [31:0]  o4_beat, o4_trunc, o4_dcnt;

    logic [1023:0] o8_d;
    logic [31:0]   o8_t;
    logic [23:0]   o8_u;
    logic [7:0]    o8_l;
    logic          o8_v, o8_drop;
    logic [1:0]    o8_beat, o8_trunc, o8_dcnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    beat_t q4[$];
    beat_t q8[$];
    int drop4_seen = 0;
    int drop8_seen = 0;
    int drop8_cyc = -1;

    dcmac_rx_seg_gather #(.IN_SEGS(2), .OUT_SEGS(4), .CNT_W(32)) dut4 (
        .clk        (clk),
        .resetn     (resetn),
        .in_tdata   (a4_d),
        .in_tid     (a4_t),
        .in_tuser   (a4_u),
        .in_tlast   (a4_l),
        .in_tvalid  (a4_v),
        .out_tdata  (o4_d),
        .out_tid    (o4_t),
        .out_tuser  (o4_u),
        .out_tlast  (o4_l),
        .out_tvalid (o4_v),
        .cnt_clear  (cnt_clear),
        .beat_cnt   (o4_beat),
        .trunc_cnt  (o4_trunc),
        .drop_cnt   (o4_dcnt),
        .drop_pulse (o4_drop)
    );

    dcmac_rx_seg_gather #(.IN_SEGS(2), .OUT_SEGS(8), .CNT_W(2)) dut8 (
        .clk        (clk),
        .resetn     (resetn),
        .in_tdata   (a8_d),
        .in_tid     (a8_t),
        .in_tuser   (a8_u),
        .in_tlast   (a8_l),
        .in_tvalid  (a8_v),
        .out_tdata  (o8_d),
        .out_tid    (o8_t),
        .out_tuser  (o8_u),
        .out_tlast  (o8_l),
        .out_tvalid (o8_v),
        .cnt_clear  (cnt_clear),
        .beat_cnt   (o8_beat),
        .trunc_cnt  (o8_trunc),
        .drop_cnt   (o8_dcnt),
        .drop_pulse (o8_drop)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_i(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic grp_t mk_grp(input bit sop, input logic [1:0] last);
        grp_t g;
        g.d = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        g.t = 8'($urandom());
        g.u = {1'b1, 1'b0, 1'($urandom()), 1'b1, sop, 1'($urandom())};
        g.l = last;
        return g;
    endfunction

    // Beat made of groups gs[0..n-1] in slots 0..n-1, remaining slots zero.
    function automatic beat_t mk_beat(input grp4_t gs, input int n, input int due);
        beat_t b;
        b.d = '0;
        b.t = '0;
        b.u = '0;
        b.l = '0;
        b.due = due;
        for (int i = 0; i < n; i++) begin
            b.d[i*256 +: 256] = gs[i].d;
            b.t[i*8 +: 8]     = gs[i].t;
            b.u[i*6 +: 6]     = gs[i].u;
            b.l[i*2 +: 2]     = gs[i].l;
        end
        return b;
    endfunction

    task automatic drive(input int sel, input grp_t g, output int c);
        @(posedge clk);
        #1;
        a4_v = 1'b0;
        a8_v = 1'b0;
        cnt_clear = 1'b0;
        if (sel == 0) begin
            a4_v = 1'b1; a4_d = g.d; a4_t = g.t; a4_u = g.u; a4_l = g.l;
        end else begin
            a8_v = 1'b1; a8_d = g.d; a8_t = g.t; a8_u = g.u; a8_l = g.l;
        end
        c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            a4_v = 1'b0;
            a8_v = 1'b0;
            cnt_clear = 1'b0;
        end
    endtask

    // Output monitor for the 2->4 instance.
    always @(negedge clk) begin
        beat_t e;
        if (o4_v) begin
            chk_i("beat4_expected", 64'(q4.size() > 0), 64'd1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk_v("beat4_data", {512'b0, o4_d}, e.d);
                chk_i("beat4_tid", 64'(o4_t), 64'(e.t[15:0]));
                chk_i("beat4_user", 64'(o4_u), 64'(e.u[11:0]));
                chk_i("beat4_last", 64'(o4_l), 64'(e.l[3:0]));
                chk_i("beat4_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (q4.size() > 0 && cyc > q4[0].due) begin
            chk_i("beat4_missing", 64'(cyc), 64'(q4[0].due));
            void'(q4.pop_front());
        end
        if (o4_drop) drop4_seen++;
    end

    // Output monitor for the 2->8 instance.
    always @(negedge clk) begin
        beat_t e;
        if (o8_v) begin
            chk_i("beat8_expected", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk_v("beat8_data", o8_d, e.d);
                chk_i("beat8_tid", 64'(o8_t), 64'(e.t));
                chk_i("beat8_user", 64'(o8_u), 64'(e.u));
                chk_i("beat8_last", 64'(o8_l), 64'(e.l));
                chk_i("beat8_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (q8.size() > 0 && cyc > q8[0].due) begin
            chk_i("beat8_missing", 64'(cyc), 64'(q8[0].due));
            void'(q8.pop_front());
        end
        if (o8_drop) begin
            drop8_seen++;
            drop8_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        grp4_t g;
        grp4_t n;
        grp4_t tg;
        beat_t b;
        int c;
        int cd;

        resetn = 1'b0;
        cnt_clear = 1'b0;
        a4_v = 1'b0; a4_d = '0; a4_t = '0; a4_u = '0; a4_l = '0;
        a8_v = 1'b0; a8_d = '0; a8_t = '0; a8_u = '0; a8_l = '0;
        for (int i = 0; i < 4; i++) begin
            g[i] = mk_grp(0, 2'b00);
            n[i] = g[i];
            tg[i] = g[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_valid4", 64'(o4_v), 64'd0);
        chk_v("rst_data4", {512'b0, o4_d}, 1024'd0);
        chk_i("rst_last4", 64'(o4_l), 64'd0);
        chk_i("rst_beat4", 64'(o4_beat), 64'd0);
        chk_i("rst_drop4", 64'(o4_drop), 64'd0);
        chk_i("rst_valid8", 64'(o8_v), 64'd0);
        chk_v("rst_data8", o8_d, 1024'd0);
        chk_i("rst_cnt8", 64'({o8_beat, o8_trunc, o8_dcnt}), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Four full groups -> two beats
        g[0] = mk_grp(1, 2'b00);
        g[1] = mk_grp(0, 2'b00);
        g[2] = mk_grp(0, 2'b00);
        g[3] = mk_grp(0, 2'b00);
        drive(0, g[0], c);
        drive(0, g[1], c);
        q4.push_back(mk_beat(g, 2, c + 2));
        drive(0, g[2], c);
        drive(0, g[3], c);
        tg[0] = g[2];
        tg[1] = g[3];
        b = mk_beat(tg, 2, c + 2);
        q4.push_back(b);
        idle(5);
        @(negedge clk);
        chk_i("a_beat_cnt", 64'(o4_beat), 64'd2);
        chk_i("a_trunc_cnt", 64'(o4_trunc), 64'd0);
        chk_v("a_hold_data", {512'b0, o4_d}, b.d);

        // Single group with eop on seg1 at slot 0 -> truncated beat
        g[0] = mk_grp(1, 2'b10);
        drive(0, g[0], c);
        q4.push_back(mk_beat(g, 1, c + 2));
        idle(5);
        @(negedge clk);
        chk_i("b_beat_cnt", 64'(o4_beat), 64'd3);
        chk_i("b_trunc_cnt", 64'(o4_trunc), 64'd1);
        chk_i("b_out3_last", 64'(o4_l[3]), 64'd0);

        // Idle gap inside a packet keeps the partial
        g[0] = mk_grp(1, 2'b00);
        drive(0, g[0], c);
        idle(3);
        g[1] = mk_grp(0, 2'b01);
        drive(0, g[1], c);
        q4.push_back(mk_beat(g, 2, c + 2));
        idle(5);
        @(negedge clk);
        chk_i("c_beat_cnt", 64'(o4_beat), 64'd4);
        chk_i("c_trunc_cnt", 64'(o4_trunc), 64'd1);

        // Clear coincident with a beat: clear wins
        g[0] = mk_grp(1, 2'b01);
        drive(0, g[0], c);
        q4.push_back(mk_beat(g, 1, c + 2));
        idle(1);
        @(posedge clk);
        #1 cnt_clear = 1'b1;
        @(posedge clk);
        #1 cnt_clear = 1'b0;
        @(negedge clk);
        chk_i("d_beat_cleared", 64'(o4_beat), 64'd0);
        chk_i("d_trunc_cleared", 64'(o4_trunc), 64'd0);
        idle(3);

        // Reset in mid-packet discards the partial silently
        g[0] = mk_grp(1, 2'b00);
        drive(0, g[0], c);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        a4_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        g[0] = mk_grp(0, 2'b00);
        g[1] = mk_grp(0, 2'b10);
        drive(0, g[0], c);
        drive(0, g[1], c);
        q4.push_back(mk_beat(g, 2, c + 2));
        idle(5);
        @(negedge clk);
        chk_i("e_beat_cnt", 64'(o4_beat), 64'd1);
        chk_i("e_trunc_cnt", 64'(o4_trunc), 64'd0);
        chk_i("e_drop_cnt", 64'(o4_dcnt), 64'd0);
        chk_i("e_drop_pulses", 64'(drop4_seen), 64'd0);

        // 2->8: eop on third group -> slots 0-2 filled, slot 3 zero
        g[0] = mk_grp(1, 2'b00);
        g[1] = mk_grp(0, 2'b00);
        g[2] = mk_grp(0, 2'b10);
        drive(1, g[0], c);
        drive(1, g[1], c);
        drive(1, g[2], c);
        q8.push_back(mk_beat(g, 3, c + 2));
        idle(5);
        @(negedge clk);
        chk_i("f_beat_cnt", 64'(o8_beat), 64'd1);
        chk_i("f_trunc_cnt", 64'(o8_trunc), 64'd1);

        // 2->8: sop on seg0 while at slot 2 -> stale partial dropped
        g[0] = mk_grp(1, 2'b00);
        g[1] = mk_grp(0, 2'b00);
        drive(1, g[0], c);
        drive(1, g[1], c);
        n[0] = mk_grp(1, 2'b00);
        n[1] = mk_grp(0, 2'b00);
        n[2] = mk_grp(0, 2'b00);
        n[3] = mk_grp(0, 2'b00);
        drive(1, n[0], c);
        cd = c + 2;
        drive(1, n[1], c);
        drive(1, n[2], c);
        drive(1, n[3], c);
        q8.push_back(mk_beat(n, 4, c + 2));
        idle(5);
        @(negedge clk);
        chk_i("g_drop_pulses", 64'(drop8_seen), 64'd1);
        chk_i("g_drop_cycle", 64'(drop8_cyc), 64'(cd));
        chk_i("g_drop_cnt", 64'(o8_dcnt), 64'd1);
        chk_i("g_beat_cnt", 64'(o8_beat), 64'd2);
        chk_i("g_trunc_cnt", 64'(o8_trunc), 64'd1);

        // 2->8 counters are 2 bits wide: drive them into saturation
        for (int k = 0; k < 3; k++) begin
            g[0] = mk_grp(1, 2'b01);
            drive(1, g[0], c);
            q8.push_back(mk_beat(g, 1, c + 2));
            idle(4);
            if (k == 0) begin
                @(negedge clk);
                chk_i("h_beat_cnt_top", 64'(o8_beat), 64'd3);
                chk_i("h_trunc_cnt_inc", 64'(o8_trunc), 64'd2);
            end
        end
        @(negedge clk);
        chk_i("h_beat_cnt_sat", 64'(o8_beat), 64'd3);
        chk_i("h_trunc_cnt_sat", 64'(o8_trunc), 64'd3);

        idle(3);
        @(negedge clk);
        chk_i("end_q4_empty", 64'(q4.size()), 64'd0);
        chk_i("end_q8_empty", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcmac_rx_seg_gather.md
DCMAC_RX_SEG_GATHER -- requirements
Module: dcmac_rx_seg_gather

Interface
REQ-001 SHALL have parameter IN_SEGS, default 2: input segments per cycle; legal 1, 2, 4.
REQ-002 SHALL have parameter OUT_SEGS, default 4: output segments per beat; an integer multiple of IN_SEGS, at most 8.
REQ-003 SHALL have parameter CNT_W, default 32: width of the statistics counters.
REQ-004 SHALL define RATIO = OUT_SEGS/IN_SEGS as a derived local constant.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 in_tdata  input  IN_SEGS*128  segment data; segment s at bits [128s+127:128s].
REQ-008 in_tid  input  IN_SEGS*4  per-segment mty.
REQ-009 in_tuser  input  IN_SEGS*3  per-segment {ena,sop,err}; bit2 ena, bit1 sop, bit0 err.
REQ-010 in_tlast  input  IN_SEGS  per-segment eop.
REQ-011 in_tvalid  input  1  group valid; all input segments move in lockstep; no tready.
REQ-012 out_tdata/out_tid/out_tuser/out_tlast  output  OUT_SEGS*(128/4/3/1)  gathered segments, same packing as inputs.
REQ-013 out_tvalid  output  1  beat valid; all output segments move in lockstep.
REQ-014 cnt_clear  input  1  synchronous clear of all statistics counters.
REQ-015 beat_cnt, trunc_cnt, drop_cnt  output  CNT_W each  statistics counters (REQ-024).
REQ-016 drop_pulse  output  1  one-cycle pulse on each stale-partial discard.

Function
REQ-017 Inputs SHALL be registered once (stage R) before any decision logic.
REQ-018 A slot counter (0..RATIO-1) SHALL select the output slot group for each valid R-stage group; slot k occupies output segments [k*IN_SEGS .. k*IN_SEGS+IN_SEGS-1].
REQ-019 A valid R group SHALL complete a beat when slot==RATIO-1 or any of its segments has tlast=1.
REQ-020 On completion: output registers <= accumulated slots plus the current group; slots above the current one zero (data, tid, tuser, tlast); out_tvalid=1 for exactly one cycle; slot<=0; accumulator cleared.
REQ-021 Without completion: the group is stored in slot `slot`, and slot increments; out_tvalid=0.
REQ-022 Latency: out_tvalid SHALL assert 2 cycles after the in_tvalid cycle carrying the completing group.
REQ-023 Realign: a valid R group whose segment 0 has sop=1 while slot!=0 SHALL cause the accumulated partial to be discarded without output, drop_pulse=1 for one cycle, and the group to be processed as slot 0 per REQ-019..021 in the same cycle.
REQ-024 Counters SHALL saturate at all-ones: beat_cnt += 1 per out_tvalid, trunc_cnt += 1 per beat completed with slot<RATIO-1, drop_cnt += 1 per drop_pulse.
REQ-025 cnt_clear SHALL zero the counters next cycle; a coincident increment is lost (clear wins).
REQ-026 RATIO==1 SHALL degenerate to a 2-cycle registered pass-through; REQ-023 never fires.
REQ-027 in_tvalid=0 cycles SHALL leave slot and accumulator unchanged, with no timeout flush.
REQ-028 Output data registers SHALL hold their value while out_tvalid=0.

Reset
REQ-029 While resetn=0: slot=0, accumulator zero, R-stage valid=0, out_tvalid=0, all output data/tid/tuser/tlast zero, counters zero, drop_pulse=0.
REQ-030 Reset mid-packet SHALL discard the partial with no output and no drop count; the first valid group after reset lands in slot 0.

Structure
REQ-031 Shared package dcmac_pkg SHALL hold SEG_DW=128, SEG_MTY_W=4, SEG_USER_W=3, and the tuser bit indices (ENA=2, SOP=1, ERR=0).
REQ-032 Counters SHALL use one sub-module, sat_counter (CNT_W, inc, clr), instantiated three times.
REQ-033 An elaboration-time check SHALL reject OUT_SEGS % IN_SEGS != 0 and OUT_SEGS > 8.

Verification
REQ-034 IN=2, OUT=4: 4 groups, no tlast -> 2 beats, each 2 cycles after the completing group; beat_cnt=2, trunc_cnt=0.
REQ-035 IN=2, OUT=4: group with seg1 tlast at slot 0 -> one beat, segs 2-3 all zero, out3_tlast=0; trunc_cnt=1.
REQ-036 IN=2, OUT=8: 3 groups with tlast on the third -> beat with slots 0-2 filled, slot 3 zero; trunc_cnt=1.
REQ-037 IN=2, OUT=8: 2 groups without tlast, then group seg0 sop=1 -> drop_pulse once, drop_cnt=1, new packet starts in slot 0, no beat from the stale data.
REQ-038 Reset asserted after 1 of 2 groups -> out_tvalid stays 0; the next packet's first group appears in segs 0-1.
REQ-039 Counters preloaded near all-ones (force) -> hold at all-ones; cnt_clear coincident with a beat -> beat_cnt=0.
